// File: rtl/xadc_drp_pkg.sv
// Shared definitions for the XADC DRP responder.
//   - DRP address/data widths
//   - register map anchors (aux results, status, config)
//   - sequencer state encoding
//   - chan_encode(): aux channel index -> 5-bit XADC channel code
package xadc_drp_pkg;

    localparam int DRP_ADDR_W = 7;
    localparam int DRP_DATA_W = 16;

    localparam logic [6:0] AUX_BASE    = 7'h10;
    localparam logic [6:0] CFG_BASE    = 7'h40;
    localparam logic [6:0] STATUS_LAST = 7'h3F;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_CONV = 2'd1,
        SEQ_EOC  = 2'd2
    } seq_state_t;

    function automatic logic [4:0] chan_encode(input logic [3:0] n);
        return {1'b1, n};
    endfunction

endpackage

// File: rtl/xadc_seq_next.sv
// Wrapped priority search for the conversion sequencer.
// Starting just above i_cur, returns the first set bit of i_mask,
// wrapping 15 -> 0 and finally considering i_cur itself, so a single
// enabled channel repeats. Feeding i_cur = 15 yields the lowest set bit.
//   i_mask  [15:0] aux channel enable mask
//   i_cur   [3:0]  current channel index
//   o_next  [3:0]  next channel index (i_cur when none enabled)
//   o_none         no channel enabled
module xadc_seq_next (
    input  logic [15:0] i_mask,
    input  logic [3:0]  i_cur,
    output logic [3:0]  o_next,
    output logic        o_none
);

    logic [3:0] v_idx;

    always_comb begin
        o_next = i_cur;
        o_none = 1'b1;
        v_idx  = i_cur;
        for (int k = 1; k <= 16; k++) begin
            v_idx = i_cur + 4'(k);
            if (o_none && i_mask[v_idx]) begin
                o_next = v_idx;
                o_none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/xadc_drp_responder.sv
// XADC DRP responder with a simple aux-channel conversion sequencer.
// Answers den/dwe/daddr/di requests with a drdy pulse RD_LATENCY cycles
// later; periodically stores sample_in into reg[0x10+n] and pulses eoc.
//   CLK100MHZ      clock, rising edge
//   reset_in       synchronous active-high reset
//   daddr_in/den_in/dwe_in/di_in   DRP request
//   do_out/drdy_out                DRP completion (do_out held)
//   sample_in      data stored on each conversion
//   seq_en_in      aux channel enable mask (bit n -> reg 0x10+n)
//   eoc_out        one-cycle end-of-conversion pulse
//   channel_out    {1'b1, n} of the last completed conversion
//   busy_out       conversion in progress
//   proto_err_out  sticky: request arrived while one was pending
//
// Sequencer states:
//   state    | meaning
//   SEQ_IDLE | mask empty, waiting for any enabled channel
//   SEQ_CONV | converting r_chan, counter runs CONV_CYCLES-1 .. 0
//   SEQ_EOC  | eoc_out pulse, pick next channel or go idle
module xadc_drp_responder
    import xadc_drp_pkg::*;
#(
    parameter int RD_LATENCY  = 4,
    parameter int CONV_CYCLES = 26,
    parameter int ADDR_W      = DRP_ADDR_W,
    parameter int DATA_W      = DRP_DATA_W
) (
    input  logic              CLK100MHZ,
    input  logic              reset_in,
    input  logic [ADDR_W-1:0] daddr_in,
    input  logic              den_in,
    input  logic              dwe_in,
    input  logic [DATA_W-1:0] di_in,
    output logic [DATA_W-1:0] do_out,
    output logic              drdy_out,
    input  logic [DATA_W-1:0] sample_in,
    input  logic [15:0]       seq_en_in,
    output logic              eoc_out,
    output logic [4:0]        channel_out,
    output logic              busy_out,
    output logic              proto_err_out
);

    logic [DATA_W-1:0] r_regs [2**ADDR_W];

    logic              r_pend;
    logic              r_pend_rd;
    logic [3:0]        r_lat_cnt;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_drdy;
    logic [DATA_W-1:0] r_do;
    logic              r_proto_err;

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic              w_load;
    logic [7:0]        r_conv_cnt;
    logic [3:0]        r_chan;
    logic [4:0]        r_chan_out;

    logic              w_accept;
    logic              w_is_cfg;
    logic              w_store;
    logic [ADDR_W-1:0] w_aux_addr;
    logic [3:0]        w_search_cur;
    logic [3:0]        w_next_idx;
    logic              w_none;

    assign w_accept   = den_in && !r_pend;
    assign w_is_cfg   = daddr_in > ADDR_W'(STATUS_LAST);
    assign w_store    = (r_state == SEQ_CONV) && (r_conv_cnt == 8'd0);
    // AUX_BASE has a zero low nibble, so OR-ing the index forms 0x10+n.
    assign w_aux_addr = ADDR_W'(AUX_BASE) | ADDR_W'(r_chan);

    // ---------------- DRP transaction timing ----------------
    always_ff @(posedge CLK100MHZ) begin
        if (reset_in) begin
            r_pend      <= 1'b0;
            r_pend_rd   <= 1'b0;
            r_lat_cnt   <= '0;
            r_rd_data   <= '0;
            r_drdy      <= 1'b0;
            r_do        <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_drdy <= 1'b0;
            if (den_in && r_pend) begin
                r_proto_err <= 1'b1;
            end
            if (r_pend) begin
                if (r_lat_cnt == 4'd1) begin
                    r_pend <= 1'b0;
                    r_drdy <= 1'b1;
                    if (r_pend_rd) begin
                        r_do <= r_rd_data;
                    end
                end else begin
                    r_lat_cnt <= r_lat_cnt - 4'd1;
                end
            end
            if (w_accept) begin
                // Read data is snapshotted at acceptance, so a conversion
                // store on the same edge is not visible to this read.
                if (RD_LATENCY == 1) begin
                    r_drdy <= 1'b1;
                    if (!dwe_in) begin
                        r_do <= r_regs[daddr_in];
                    end
                end else begin
                    r_pend    <= 1'b1;
                    r_lat_cnt <= 4'(RD_LATENCY - 1);
                    r_pend_rd <= !dwe_in;
                    r_rd_data <= r_regs[daddr_in];
                end
            end
        end
    end

    // ---------------- register array ----------------
    always_ff @(posedge CLK100MHZ) begin
        if (reset_in) begin
            for (int i = 0; i < 2**ADDR_W; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_accept && dwe_in && w_is_cfg) begin
                r_regs[daddr_in] <= di_in;
            end
            // Aux addresses are below the config window, so these never collide.
            if (w_store) begin
                r_regs[w_aux_addr] <= sample_in;
            end
        end
    end

    // ---------------- conversion sequencer ----------------
    assign w_search_cur = (r_state == SEQ_IDLE) ? 4'hF : r_chan;

    xadc_seq_next u_seq_next (
        .i_mask (seq_en_in),
        .i_cur  (w_search_cur),
        .o_next (w_next_idx),
        .o_none (w_none)
    );

    always_ff @(posedge CLK100MHZ) begin
        if (reset_in) begin
            r_state <= SEQ_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            SEQ_IDLE: begin
                if (!w_none) begin
                    w_state_nxt = SEQ_CONV;
                    w_load      = 1'b1;
                end
            end
            SEQ_CONV: begin
                if (r_conv_cnt == 8'd0) begin
                    w_state_nxt = SEQ_EOC;
                end
            end
            SEQ_EOC: begin
                if (w_none) begin
                    w_state_nxt = SEQ_IDLE;
                end else begin
                    w_state_nxt = SEQ_CONV;
                    w_load      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = SEQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset_in) begin
            r_conv_cnt <= '0;
            r_chan     <= '0;
            r_chan_out <= '0;
        end else begin
            if (w_load) begin
                r_conv_cnt <= 8'(CONV_CYCLES - 1);
                r_chan     <= w_next_idx;
            end else if ((r_state == SEQ_CONV) && (r_conv_cnt != 8'd0)) begin
                r_conv_cnt <= r_conv_cnt - 8'd1;
            end
            if (w_store) begin
                r_chan_out <= chan_encode(r_chan);
            end
        end
    end

    assign do_out        = r_do;
    assign drdy_out      = r_drdy;
    assign eoc_out       = (r_state == SEQ_EOC);
    assign busy_out      = (r_state == SEQ_CONV);
    assign channel_out   = r_chan_out;
    assign proto_err_out = r_proto_err;

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Directed bench for xadc_drp_responder (RD_LATENCY=4, CONV_CYCLES=26).
module tb_xadc_drp_responder;

    logic        CLK100MHZ = 1'b0;
    logic        reset_in;
    logic [6:0]  daddr_in;
    logic        den_in;
    logic        dwe_in;
    logic [15:0] di_in;
    logic [15:0] do_out;
    logic        drdy_out;
    logic [15:0] sample_in;
    logic [15:0] seq_en_in;
    logic        eoc_out;
    logic [4:0]  channel_out;
    logic        busy_out;
    logic        proto_err_out;

    int n_err = 0;
    int n_chk = 0;

    always #5 CLK100MHZ = ~CLK100MHZ;

    xadc_drp_responder dut (
        .CLK100MHZ     (CLK100MHZ),
        .reset_in      (reset_in),
        .daddr_in      (daddr_in),
        .den_in        (den_in),
        .dwe_in        (dwe_in),
        .di_in         (di_in),
        .do_out        (do_out),
        .drdy_out      (drdy_out),
        .sample_in     (sample_in),
        .seq_en_in     (seq_en_in),
        .eoc_out       (eoc_out),
        .channel_out   (channel_out),
        .busy_out      (busy_out),
        .proto_err_out (proto_err_out)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK100MHZ);
        #1;
    endtask

    // One DRP request; returns cycles from den to drdy (-1 on timeout)
    // and do_out in the drdy cycle. Returns while still in the drdy cycle.
    task automatic drp_xfer(input logic we, input logic [6:0] addr, input logic [15:0] data,
                            output int lat, output logic [15:0] rdata);
        den_in   = 1'b1;
        dwe_in   = we;
        daddr_in = addr;
        di_in    = data;
        lat      = -1;
        rdata    = 16'h0;
        tick();
        den_in = 1'b0;
        dwe_in = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (drdy_out) begin
                lat   = k;
                rdata = do_out;
                break;
            end
            tick();
        end
    endtask

    // Cycles until the next eoc pulse (-1 if none within limit).
    task automatic wait_eoc(input int limit, output int cyc);
        cyc = -1;
        for (int k = 1; k <= limit; k++) begin
            tick();
            if (eoc_out) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        reset_in = 1'b1;
        den_in   = 1'b0;
        dwe_in   = 1'b0;
        tick();
        tick();
        reset_in = 1'b0;
    endtask

    int          lat;
    int          cyc;
    int          seen;
    int          first_at;
    logic [15:0] rd;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_in  = 1'b1;
        daddr_in  = '0;
        den_in    = 1'b0;
        dwe_in    = 1'b0;
        di_in     = '0;
        sample_in = '0;
        seq_en_in = '0;
        tick();
        tick();
        tick();
        reset_in = 1'b0;
        tick();

        check_val("rst_do",    32'(do_out), 32'h0);
        check_val("rst_drdy",  32'(drdy_out), 32'h0);
        check_val("rst_eoc",   32'(eoc_out), 32'h0);
        check_val("rst_chan",  32'(channel_out), 32'h0);
        check_val("rst_busy",  32'(busy_out), 32'h0);
        check_val("rst_err",   32'(proto_err_out), 32'h0);

        // Read timing
        drp_xfer(1'b0, 7'h40, 16'h0, lat, rd);
        check_val("rd40_lat",  32'(lat), 32'd4);
        check_val("rd40_data", 32'(rd), 32'h0);
        tick();
        check_val("rd40_single_pulse", 32'(drdy_out), 32'h0);

        // Write / readback, issued back-to-back in drdy cycles
        drp_xfer(1'b1, 7'h41, 16'hBEEF, lat, rd);
        check_val("wr41_lat",  32'(lat), 32'd4);
        check_val("wr41_do_held", 32'(do_out), 32'h0);
        drp_xfer(1'b0, 7'h41, 16'h0, lat, rd);
        check_val("rd41_lat",  32'(lat), 32'd4);
        check_val("rd41_data", 32'(rd), 32'hBEEF);
        drp_xfer(1'b1, 7'h12, 16'h1234, lat, rd);
        check_val("wr12_lat",  32'(lat), 32'd4);
        check_val("wr12_do_held", 32'(do_out), 32'hBEEF);
        drp_xfer(1'b0, 7'h12, 16'h0, lat, rd);
        check_val("rd12_data", 32'(rd), 32'h0);
        check_val("b2b_no_err", 32'(proto_err_out), 32'h0);
        tick();

        // Overlapping requests
        den_in   = 1'b1;
        daddr_in = 7'h41;
        tick();
        daddr_in = 7'h40;
        tick();
        den_in   = 1'b0;
        seen     = 0;
        first_at = -1;
        for (int k = 2; k <= 12; k++) begin
            if (drdy_out) begin
                seen++;
                if (first_at < 0) begin
                    first_at = k;
                    rd       = do_out;
                end
            end
            tick();
        end
        check_val("ovl_drdy_count", 32'(seen), 32'd1);
        check_val("ovl_drdy_time",  32'(first_at), 32'd4);
        check_val("ovl_data",       32'(rd), 32'hBEEF);
        check_val("ovl_err",        32'(proto_err_out), 32'h1);
        drp_xfer(1'b0, 7'h40, 16'h0, lat, rd);
        check_val("ovl_err_sticky", 32'(proto_err_out), 32'h1);
        apply_reset();
        check_val("ovl_err_cleared", 32'(proto_err_out), 32'h0);

        // Sequencing over channels 0 and 4
        sample_in = 16'hA000;
        seq_en_in = 16'h0011;
        wait_eoc(60, cyc);
        check_val("seq_first_time", 32'(cyc), 32'd27);
        check_val("seq_chan0",      32'(channel_out), 32'h10);
        check_val("seq_eoc_busy",   32'(busy_out), 32'h0);
        wait_eoc(60, cyc);
        check_val("seq_period1",    32'(cyc), 32'd27);
        check_val("seq_chan4",      32'(channel_out), 32'h14);
        wait_eoc(60, cyc);
        check_val("seq_period2",    32'(cyc), 32'd27);
        check_val("seq_chan0_wrap", 32'(channel_out), 32'h10);
        tick();
        tick();
        check_val("seq_busy_mid",   32'(busy_out), 32'h1);
        check_val("seq_no_eoc_mid", 32'(eoc_out), 32'h0);
        drp_xfer(1'b0, 7'h14, 16'h0, lat, rd);
        check_val("rd14_data",      32'(rd), 32'hA000);

        // Read/store collision on 0x10
        seq_en_in = 16'h0000;
        apply_reset();
        sample_in = 16'h1111;
        seq_en_in = 16'h0001;
        wait_eoc(60, cyc);
        check_val("col_first_eoc", 32'(cyc), 32'd27);
        sample_in = 16'h5555;
        for (int k = 0; k < 26; k++) begin
            tick();
        end
        drp_xfer(1'b0, 7'h10, 16'h0, lat, rd);
        check_val("col_pre_store", 32'(rd), 32'h1111);
        drp_xfer(1'b0, 7'h10, 16'h0, lat, rd);
        check_val("col_post_store", 32'(rd), 32'h5555);

        // Reset in the middle of a pending read
        seq_en_in = 16'h0000;
        drp_xfer(1'b1, 7'h41, 16'hCAFE, lat, rd);
        drp_xfer(1'b0, 7'h41, 16'h0, lat, rd);
        check_val("mid_pre_data", 32'(rd), 32'hCAFE);
        tick();
        den_in   = 1'b1;
        daddr_in = 7'h41;
        tick();
        den_in = 1'b0;
        tick();
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (drdy_out) seen++;
            tick();
        end
        check_val("mid_no_drdy", 32'(seen), 32'd0);
        check_val("mid_do",      32'(do_out), 32'h0);
        check_val("mid_chan",    32'(channel_out), 32'h0);
        check_val("mid_busy",    32'(busy_out), 32'h0);
        check_val("mid_eoc",     32'(eoc_out), 32'h0);
        drp_xfer(1'b0, 7'h41, 16'h0, lat, rd);
        check_val("mid_cfg_cleared", 32'(rd), 32'h0);
        drp_xfer(1'b0, 7'h10, 16'h0, lat, rd);
        check_val("mid_aux_cleared", 32'(rd), 32'h0);
        check_val("mid_idle_busy",   32'(busy_out), 32'h0);
        seq_en_in = 16'h8000;
        wait_eoc(60, cyc);
        check_val("mid_restart_time", 32'(cyc), 32'd27);
        check_val("mid_chan15",       32'(channel_out), 32'h1F);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
